// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, instruction classes and control encodings for the ALU sequencer.
package alu_seq_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP
  } stateT;
  typedef enum logic [2:0] {CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_ILL} clsT;
  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] FN_MOVZ     = 6'b001010;
  localparam logic [5:0] FN_MOVN     = 6'b001011;
  localparam logic [5:0] FN_CLZ      = 6'b100000;
  localparam logic [5:0] FN_CLO      = 6'b100001;
  localparam logic [5:0] FN_SUB      = 6'b100010;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;
  localparam logic [1:0] PC_ALU      = 2'b00;
  localparam logic [1:0] PC_BRANCH   = 2'b01;
  localparam logic [1:0] PC_JUMP     = 2'b10;
  localparam logic [1:0] ALUOP_R     = 2'b00;
  localparam logic [1:0] ALUOP_CL    = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: classifies the latched instruction for the sequencer FSM.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] instruction,
  output clsT         cls,
  output logic        isMovn,
  output logic        isMovz,
  output logic        isSpecial2,
  output logic        isBne
);
  logic [5:0] op, fn;
  logic unusedBits;
  assign op = instruction[31:26];
  assign fn = instruction[5:0];
  assign unusedBits = ^instruction[25:6];
  assign isSpecial2 = op == OP_SPECIAL2 && (fn == FN_CLZ || fn == FN_CLO);
  assign isMovn = op == OP_RTYPE && fn == FN_MOVN;
  assign isMovz = op == OP_RTYPE && fn == FN_MOVZ;
  assign isBne = op == OP_BNE;
  assign cls = (op == OP_RTYPE || isSpecial2) ? CLS_R :
               (op == OP_ADDI || op == OP_ADDIU) ? CLS_I :
               op == OP_LW ? CLS_LW :
               op == OP_SW ? CLS_SW :
               (op == OP_BEQ || isBne) ? CLS_BR :
               op == OP_J ? CLS_J : CLS_ILL;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multicycle fetch/decode/execute/writeback control FSM with memory timeout.
// Define TRAP_ON_ILLEGAL_EN to trap on illegal opcodes; otherwise they act as NOPs.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        memDone,
  input  logic        zeroFlag,
  input  logic        rtZero,
  output logic [5:0]  operation,
  output logic [1:0]  opCode,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        regWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic        memError,
  output logic        trap,
  output logic [3:0]  state
);
  localparam int CW = $clog2(MEM_TIMEOUT);
`ifdef TRAP_ON_ILLEGAL_EN
  localparam stateT ILLEGAL_NEXT = TRAP;
`else
  localparam stateT ILLEGAL_NEXT = FETCH;
`endif
  stateT curState, nextState;
  clsT cls;
  logic [CW-1:0] waitCnt;
  logic isMovn, isMovz, isSpecial2, isBne, waitState, timeout, brTaken;
  alu_seq_decode uDec (
    .instruction(instruction),
    .cls(cls),
    .isMovn(isMovn),
    .isMovz(isMovz),
    .isSpecial2(isSpecial2),
    .isBne(isBne)
  );
  assign state = curState;
  assign waitState = curState inside {FETCH, MEM_RD, MEM_WR};
  assign timeout = waitState && !memDone && waitCnt == CW'(MEM_TIMEOUT - 1);
  assign brTaken = isBne ^ zeroFlag;
`ifdef TRAP_ON_ILLEGAL_EN
  assign trap = curState == TRAP && !reset;
`else
  assign trap = 1'b0;
`endif
  // A FETCH timeout re-enters FETCH, so the counter must clear on timeout as well as on a state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= FETCH;
      waitCnt <= '0;
    end else begin
      curState <= nextState;
      waitCnt <= (waitState && nextState == curState && !timeout) ? waitCnt + CW'(1) : '0;
    end
  end
  // Strobes are gated by reset so nothing is written while an instruction is being abandoned.
  always_comb begin
    nextState = curState;
    operation = '0;
    opCode = '0;
    aluSrcA = 1'b0;
    aluSrcB = SRCB_RT;
    memRead = 1'b0;
    memWrite = 1'b0;
    irWrite = 1'b0;
    pcWrite = 1'b0;
    pcSrc = PC_ALU;
    regWrite = 1'b0;
    regDst = 1'b0;
    memToReg = 1'b0;
    memError = 1'b0;
    if (!reset) begin
      case (curState)
        FETCH: begin
          memRead = 1'b1;
          aluSrcB = SRCB_FOUR;
          opCode = ALUOP_ADD;
          irWrite = memDone;
          pcWrite = memDone;
          memError = timeout;
          nextState = memDone ? DECODE : FETCH;
        end
        DECODE: begin
          aluSrcB = SRCB_IMMSH;
          opCode = ALUOP_ADD;
          nextState = cls == CLS_R ? EXEC_R :
                      cls == CLS_I ? EXEC_I :
                      (cls == CLS_LW || cls == CLS_SW) ? MEM_ADDR :
                      cls == CLS_BR ? BRANCH :
                      cls == CLS_J ? JUMP : ILLEGAL_NEXT;
        end
        EXEC_R: begin
          aluSrcA = 1'b1;
          operation = instruction[5:0];
          opCode = isSpecial2 ? ALUOP_CL : ALUOP_R;
          nextState = WB_R;
        end
        EXEC_I, MEM_ADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
          opCode = ALUOP_ADD;
          nextState = curState == EXEC_I ? WB_I : cls == CLS_LW ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          memRead = 1'b1;
          memError = timeout;
          nextState = memDone ? WB_MEM : timeout ? FETCH : MEM_RD;
        end
        MEM_WR: begin
          memWrite = 1'b1;
          memError = timeout;
          nextState = (memDone || timeout) ? FETCH : MEM_WR;
        end
        WB_R: begin
          regWrite = isMovn ? !rtZero : isMovz ? rtZero : 1'b1;
          regDst = 1'b1;
          nextState = FETCH;
        end
        WB_I: begin
          regWrite = 1'b1;
          nextState = FETCH;
        end
        WB_MEM: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
          nextState = FETCH;
        end
        BRANCH: begin
          aluSrcA = 1'b1;
          operation = FN_SUB;
          pcWrite = brTaken;
          pcSrc = brTaken ? PC_BRANCH : PC_ALU;
          nextState = FETCH;
        end
        JUMP: begin
          pcWrite = 1'b1;
          pcSrc = PC_JUMP;
          nextState = FETCH;
        end
        TRAP: nextState = TRAP;
        default: nextState = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench; a reference model plans per-cycle expectations, a monitor checks them.
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  typedef struct packed {
    logic [3:0] st; logic [5:0] op; logic [1:0] opc; logic a; logic [1:0] b;
    logic mr, mw, ir, pw; logic [1:0] ps; logic rw, rd, m2r, err, trp;
  } rec_t;
  typedef struct packed {logic rst; logic [31:0] ins; logic md, zf, rz;} drv_t;
  typedef struct packed {logic chk; rec_t r;} exp_t;
  drv_t drvQ[$];
  exp_t expQ[$];
  logic clk = 0, reset = 1, memDone = 0, zeroFlag = 0, rtZero = 0;
  logic [31:0] instruction = '0;
  logic [5:0] operation;
  logic [1:0] opCode, aluSrcB, pcSrc;
  logic aluSrcA, memRead, memWrite, irWrite, pcWrite, regWrite, regDst, memToReg, memError, trap;
  logic [3:0] state;
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] curIns = '0;
  logic curZf = 0, curRz = 0;
  exp_t monE;
  rec_t monGot;
  drv_t drvE;

  alu_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .memDone(memDone),
    .zeroFlag(zeroFlag), .rtZero(rtZero), .operation(operation), .opCode(opCode),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
    .regDst(regDst), .memToReg(memToReg), .memError(memError), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  function automatic rec_t blank(logic [3:0] s);
    rec_t r = '0;
    r.st = s;
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic put(rec_t r, logic md, logic chk, logic rst);
    drvQ.push_back('{rst, curIns, md, curZf, curRz});
    expQ.push_back('{chk, r});
  endtask

  task automatic doReset();
    put(blank(FETCH), rb(), 1'b0, 1'b1);
    put(blank(FETCH), rb(), 1'b1, 1'b1);
  endtask

  // 16 wait cycles per timeout; fW idle cycles then a completing memDone.
  task automatic fetchPhase(int fTo, int fW);
    rec_t r = blank(FETCH);
    r.mr = 1; r.b = 2'b01; r.opc = 2'b10;
    repeat (fTo) begin
      for (int i = 0; i < 15; i++) put(r, 1'b0, 1'b1, 1'b0);
      r.err = 1; put(r, 1'b0, 1'b1, 1'b0); r.err = 0;
    end
    for (int i = 0; i < fW; i++) put(r, 1'b0, 1'b1, 1'b0);
    r.ir = 1; r.pw = 1;
    put(r, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic memPhase(logic [3:0] s, bit isRd, int mTo, int mW, output bit done);
    rec_t r = blank(s);
    if (isRd) r.mr = 1; else r.mw = 1;
    done = 0;
    if (mTo != 0) begin
      for (int i = 0; i < 15; i++) put(r, 1'b0, 1'b1, 1'b0);
      r.err = 1; put(r, 1'b0, 1'b1, 1'b0);
      return;
    end
    for (int i = 0; i < mW; i++) put(r, 1'b0, 1'b1, 1'b0);
    put(r, 1'b1, 1'b1, 1'b0);
    done = 1;
  endtask

  task automatic doInstr(logic [31:0] ins, int fTo, int fW, int mTo, int mW, bit zf, bit rz);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    rec_t r;
    bit done;
    curIns = ins; curZf = zf; curRz = rz;
    fetchPhase(fTo, fW);
    r = blank(DECODE); r.b = 2'b11; r.opc = 2'b10;
    put(r, rb(), 1'b1, 1'b0);
    if (op == 6'h00 || (op == 6'h1c && (fn == 6'h20 || fn == 6'h21))) begin
      r = blank(EXEC_R); r.a = 1; r.op = fn; r.opc = op == 6'h1c ? 2'b01 : 2'b00;
      put(r, rb(), 1'b1, 1'b0);
      r = blank(WB_R); r.rd = 1;
      r.rw = (op == 6'h00 && fn == 6'h0b) ? !rz : (op == 6'h00 && fn == 6'h0a) ? rz : 1'b1;
      put(r, rb(), 1'b1, 1'b0);
    end else if (op == 6'h08 || op == 6'h09) begin
      r = blank(EXEC_I); r.a = 1; r.b = 2'b10; r.opc = 2'b10;
      put(r, rb(), 1'b1, 1'b0);
      r = blank(WB_I); r.rw = 1;
      put(r, rb(), 1'b1, 1'b0);
    end else if (op == 6'h23 || op == 6'h2b) begin
      r = blank(MEM_ADDR); r.a = 1; r.b = 2'b10; r.opc = 2'b10;
      put(r, rb(), 1'b1, 1'b0);
      memPhase(op == 6'h23 ? MEM_RD : MEM_WR, op == 6'h23, mTo, mW, done);
      if (done && op == 6'h23) begin
        r = blank(WB_MEM); r.rw = 1; r.m2r = 1;
        put(r, rb(), 1'b1, 1'b0);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      r = blank(BRANCH); r.a = 1; r.op = 6'b100010;
      if ((op == 6'h04 && zf) || (op == 6'h05 && !zf)) begin r.pw = 1; r.ps = 2'b01; end
      put(r, rb(), 1'b1, 1'b0);
    end else if (op == 6'h02) begin
      r = blank(JUMP); r.pw = 1; r.ps = 2'b10;
      put(r, rb(), 1'b1, 1'b0);
    end else begin
`ifdef TRAP_ON_ILLEGAL_EN
      r = blank(TRAP); r.trp = 1;
      repeat (3) put(r, rb(), 1'b1, 1'b0);
      doReset();
`endif
    end
  endtask

  task automatic swResetCut();
    rec_t r;
    curIns = 32'hAC220008; curZf = 0; curRz = 0;
    fetchPhase(0, 0);
    r = blank(DECODE); r.b = 2'b11; r.opc = 2'b10; put(r, 1'b0, 1'b1, 1'b0);
    r = blank(MEM_ADDR); r.a = 1; r.b = 2'b10; r.opc = 2'b10; put(r, 1'b0, 1'b1, 1'b0);
    r = blank(MEM_WR); r.mw = 1;
    put(r, 1'b0, 1'b1, 1'b0);
    put(r, 1'b0, 1'b1, 1'b0);
    doReset();
  endtask

  task automatic randInstr();
    logic [31:0] rnd = $urandom();
    logic [31:0] ins;
    int k = $urandom_range(0, 12);
    int fTo = $urandom_range(0, 9) == 0 ? 1 : 0;
    int fW = $urandom_range(0, 7) == 0 ? 15 : $urandom_range(0, 3);
    int mTo = $urandom_range(0, 7) == 0 ? 1 : 0;
    int mW = $urandom_range(0, 7) == 0 ? 15 : $urandom_range(0, 3);
    case (k)
      0: ins = {6'h00, rnd[25:0]};
      1: ins = {6'h00, rnd[25:6], 6'h0b};
      2: ins = {6'h00, rnd[25:6], 6'h0a};
      3: ins = {6'h1c, rnd[25:6], 6'h20};
      4: ins = {6'h1c, rnd[25:6], 6'h21};
      5: ins = {6'h08, rnd[25:0]};
      6: ins = {6'h09, rnd[25:0]};
      7: ins = {6'h23, rnd[25:0]};
      8: ins = {6'h2b, rnd[25:0]};
      9: ins = {6'h04, rnd[25:0]};
      10: ins = {6'h05, rnd[25:0]};
      11: ins = {6'h02, rnd[25:0]};
      default: ins = rnd[0] ? {6'h3f, rnd[25:0]} : {6'h1c, rnd[25:6], 6'h02};
    endcase
    doInstr(ins, fTo, fW, mTo, mW, rb(), rb());
  endtask

  always @(negedge clk) begin
    cyc++;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      monGot = {state, operation, opCode, aluSrcA, aluSrcB, memRead, memWrite, irWrite, pcWrite,
                pcSrc, regWrite, regDst, memToReg, memError, trap};
      if (monE.chk) begin
        total++;
        if (monGot !== monE.r) begin
          bad++;
          $display("FAIL cycle %0d ctrl: got=%h expected=%h (state got=%0d expected=%0d)",
                   cyc, monGot, monE.r, monGot.st, monE.r.st);
        end
      end
    end
  end

  initial begin
    doReset();
    doInstr(32'h00221820, 0, 0, 0, 0, 0, 0);
    doInstr(32'h8C220004, 0, 1, 0, 3, 0, 0);
    doInstr(32'h10220003, 0, 0, 0, 0, 1, 0);
    doInstr(32'h14220003, 0, 0, 0, 0, 1, 0);
    doInstr(32'h14220003, 0, 0, 0, 0, 0, 0);
    doInstr(32'h00221820, 1, 0, 0, 0, 0, 0);
    doInstr(32'h00221820, 0, 15, 0, 0, 0, 0);
    doInstr(32'h0022180A, 0, 0, 0, 0, 0, 0);
    doInstr(32'h0022180A, 0, 0, 0, 0, 0, 1);
    doInstr(32'h70201020, 0, 2, 0, 0, 0, 0);
    doInstr(32'h20220005, 0, 0, 0, 0, 0, 0);
    doInstr(32'hAC220008, 0, 0, 0, 2, 0, 0);
    doInstr(32'hAC220008, 0, 0, 1, 0, 0, 0);
    doInstr(32'h8C220004, 0, 0, 0, 15, 0, 0);
    doInstr(32'h08000010, 0, 0, 0, 0, 0, 0);
    doInstr(32'hFC000000, 0, 0, 0, 0, 0, 0);
    doReset();
    swResetCut();
    for (int i = 0; i < 60; i++) randInstr();
    while (drvQ.size() > 0) begin
      @(posedge clk);
      #1;
      drvE = drvQ.pop_front();
      reset = drvE.rst;
      instruction = drvE.ins;
      memDone = drvE.md;
      zeroFlag = drvE.zf;
      rtZero = drvE.rz;
    end
    @(negedge clk);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
